// File: rtl/data_type_pkg.sv
// Shared types and constants for the sequential bfloat16 divider.
// Holds the FSM state encoding, the canonical quiet NaN and the iteration count.
package data_type_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int EXP_BIAS   = 127;
  localparam int DIV_ITER   = 10;

  localparam logic [DATA_WIDTH-1:0] QNAN = 16'h7FC0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fp_div_state_t;

endpackage

// File: rtl/mant_div_iter.sv
// Restoring mantissa divider: one quotient bit per step, MSB first.
// Q = floor(ma * 2^(QW-1) / mb) and R is the final remainder once last_o is seen.
module mant_div_iter #(
  parameter int MW = 8,
  parameter int QW = 10,
  parameter int CW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          step_i,
  input  logic [MW-1:0] ma_i,
  input  logic [MW-1:0] mb_i,
  output logic [QW-1:0] q_o,
  output logic [MW:0]   r_o,
  output logic          last_o
);

  logic [MW:0]   rem_q, rem_d, rem_sub;
  logic [MW-1:0] div_q, div_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ge;
  logic          last;

  assign last = (cnt_q == '0);

  always_comb begin
    ge      = (rem_q >= {1'b0, div_q});
    rem_sub = ge ? (rem_q - {1'b0, div_q}) : rem_q;
    rem_d   = rem_q;
    div_d   = div_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    if (start_i) begin
      rem_d = {1'b0, ma_i};
      div_d = mb_i;
      quo_d = '0;
      cnt_d = CW'(QW - 1);
    end else if (step_i) begin
      quo_d = {quo_q[QW-2:0], ge};
      // After a subtraction rem_sub < mb, so the shift never loses a bit.
      rem_d = last ? rem_sub : {rem_sub[MW-1:0], 1'b0};
      if (!last) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rem_q <= '0;
      div_q <= '0;
      quo_q <= '0;
      cnt_q <= '0;
    end else begin
      rem_q <= rem_d;
      div_q <= div_d;
      quo_q <= quo_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_o    = quo_q;
  assign r_o    = rem_q;
  assign last_o = last;

endmodule

// File: rtl/fp_div_seq.sv
// Sequential bfloat16 divider: specials resolved at acceptance, normal operands
// go through a 10-step restoring divide, then one rounding/packing cycle.
module fp_div_seq
  import data_type_pkg::*;
#(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 7
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in1_i,
  input  logic [DATA_WIDTH-1:0] in2_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_o,
  output logic                  overflow_o,
  output fp_div_state_t         dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and DONE holds its payload until taken.

  localparam int MW = FRAC_WIDTH + 1;
  localparam int EW = EXP_WIDTH + 2;
  localparam int CW = $clog2(DIV_ITER);

  localparam logic signed [EW-1:0] BIAS_S = EW'(EXP_BIAS);
  localparam logic signed [EW-1:0] EMAX_S = EW'((1 << EXP_WIDTH) - 1);
  localparam logic signed [EW-1:0] ONE_S  = EW'(1);
  localparam logic signed [EW-1:0] ZERO_S = '0;

  fp_div_state_t state_q, state_d;

  logic                  sign_q, sign_d;
  logic signed [EW-1:0]  ebase_q, ebase_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  ovf_q, ovf_d;

  logic                  sign1, sign2, sign_x;
  logic [EXP_WIDTH-1:0]  exp1, exp2;
  logic [FRAC_WIDTH-1:0] frac1, frac2;
  logic                  accept;
  logic                  is_special;
  logic [DATA_WIDTH-1:0] spec_res;
  logic                  spec_ovf;

  logic [DIV_ITER-1:0]   quo_w;
  logic [MW:0]           rem_w;
  logic                  last_w;

  assign sign1  = in1_i[DATA_WIDTH-1];
  assign sign2  = in2_i[DATA_WIDTH-1];
  assign exp1   = in1_i[DATA_WIDTH-2 -: EXP_WIDTH];
  assign exp2   = in2_i[DATA_WIDTH-2 -: EXP_WIDTH];
  assign frac1  = in1_i[FRAC_WIDTH-1:0];
  assign frac2  = in2_i[FRAC_WIDTH-1:0];
  assign sign_x = sign1 ^ sign2;
  assign accept = in_valid_i && (state_q == IDLE);

  // Special operands: NaN/Inf first, then zero/denormal divisor, then zero dividend.
  always_comb begin
    is_special = 1'b1;
    spec_res   = '0;
    spec_ovf   = 1'b0;
    if ((&exp1) || (&exp2)) begin
      spec_res = QNAN;
    end else if (exp2 == '0) begin
      spec_res = {sign_x, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
      spec_ovf = 1'b1;
    end else if (exp1 == '0) begin
      spec_res = {sign_x, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      is_special = 1'b0;
    end
  end

  mant_div_iter #(
    .MW (MW),
    .QW (DIV_ITER),
    .CW (CW)
  ) u_mant_div_iter (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (accept && !is_special),
    .step_i  (state_q == BUSY),
    .ma_i    ({1'b1, frac1}),
    .mb_i    ({1'b1, frac2}),
    .q_o     (quo_w),
    .r_o     (rem_w),
    .last_o  (last_w)
  );

  logic                  q_top;
  logic [FRAC_WIDTH-1:0] frac_n, frac_sum;
  logic                  rnd, sticky, round_up, carry;
  logic signed [EW-1:0]  e_norm, e_fin;
  logic [DATA_WIDTH-1:0] norm_res;
  logic                  norm_ovf;

  // Normalise the 10-bit quotient to an 8-bit mantissa (hidden bit dropped),
  // round to nearest even, and fold a mantissa carry into the exponent.
  always_comb begin
    q_top    = quo_w[DIV_ITER-1];
    frac_n   = q_top ? quo_w[DIV_ITER-2 -: FRAC_WIDTH] : quo_w[DIV_ITER-3 -: FRAC_WIDTH];
    rnd      = q_top ? quo_w[DIV_ITER-2-FRAC_WIDTH] : quo_w[DIV_ITER-3-FRAC_WIDTH];
    sticky   = (q_top & quo_w[0]) | (rem_w != '0);
    round_up = rnd & (sticky | frac_n[0]);
    {carry, frac_sum} = {1'b0, frac_n} + {{FRAC_WIDTH{1'b0}}, round_up};
    e_norm   = q_top ? (ebase_q + BIAS_S) : (ebase_q + BIAS_S - ONE_S);
    e_fin    = carry ? (e_norm + ONE_S) : e_norm;
    norm_ovf = 1'b0;
    if (e_fin >= EMAX_S) begin
      norm_res = {sign_q, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
      norm_ovf = 1'b1;
    end else if (e_fin <= ZERO_S) begin
      norm_res = {sign_q, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      norm_res = {sign_q, e_fin[EXP_WIDTH-1:0], frac_sum};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = is_special ? DONE : BUSY;
      BUSY:  if (last_w) state_d = ROUND;
      ROUND: state_d = DONE;
      DONE:  if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sign_d  = sign_q;
    ebase_d = ebase_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sign_d  = sign_x;
          ebase_d = $signed({2'b00, exp1}) - $signed({2'b00, exp2});
          if (is_special) begin
            res_d = spec_res;
            ovf_d = spec_ovf;
          end
        end
      end
      ROUND: begin
        res_d = norm_res;
        ovf_d = norm_ovf;
      end
      DONE: begin
        if (out_ready_i) begin
          res_d = '0;
          ovf_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sign_q  <= 1'b0;
      ebase_q <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sign_q  <= sign_d;
      ebase_q <= ebase_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    in_ready_o  = (state_q == IDLE);
    out_valid_o = (state_q == DONE);
    out_o       = out_valid_o ? res_q : '0;
    overflow_o  = out_valid_o ? ovf_q : 1'b0;
    dbg_state_o = state_q;
  end

endmodule
